motor_cmd_seq: RTL and testbench
================================

# motor_cmd_seq

Motor command sequencer placed directly upstream of the PWM motor stage; it drives that stage's 2-bit `speed` input. It accepts direction requests from the tracking/turn logic over a valid/ready handshake. It inserts a timed brake phase, and a dead-time phase on reversal, so the motor is never switched straight from one drive direction to the other or left coasting after a stop request.

## Interface
- `BRAKE_US`, default 200000: brake phase length in `clkus` cycles (µs).
- `DEAD_US`, default 50000: dead-time (STOP output) length between brake and reverse drive, in cycles.
- `WDOG_US`, default 500000: watchdog timeout in cycles; used only with the watchdog macro.
- `CNT_W`, default 20: phase counter width; must hold max(BRAKE_US, DEAD_US, WDOG_US).

- `clkus` in 1: 1 MHz clock. One clock; reset is asynchronous, active-low.
- `rst_n` in 1: asynchronous active-low reset.
- `cmd_valid` in 1: request present.
- `cmd` in 2: requested motion; 00 STOP, 01 FOR, 10 BACK, 11 BRAKE.
- `cmd_ready` out 1: request can be accepted this cycle.
- `speed` out 2: code to the motor stage, same encoding as `cmd`.
- `busy` out 1: high in BRAKE or DEAD phase.

## Operation
- States: S_STOP, S_FOR, S_BACK (stable), S_BRK, S_DEAD (transient). Reset state is S_STOP.
- `speed` is registered. Values per state: S_STOP 00, S_FOR 01, S_BACK 10, S_BRK 11, S_DEAD 00.
- `cmd_ready` is 1 in stable states and 0 in transient states. A request is accepted when `cmd_valid && cmd_ready`.
- Accepted request in S_STOP:
  - FOR goes to S_FOR; BACK goes to S_BACK.
  - BRAKE goes to S_BRK, with `pending` = STOP.
  - STOP is a no-op.
- Accepted request in S_FOR (mirror everything for S_BACK):
  - FOR is a no-op.
  - STOP or BRAKE goes to S_BRK, with `pending` = STOP.
  - BACK goes to S_BRK, with `pending` = BACK.
- S_BRK: the counter runs for BRAKE_US cycles, then:
  - `pending` STOP goes to S_STOP.
  - `pending` FOR/BACK goes to S_DEAD.
- S_DEAD: the counter runs for DEAD_US cycles, then goes to the `pending` direction state.
- Counter behaviour: cleared on every state entry; increments in transient states; terminal at value −1.
- No request is queued during transient states. Upstream holds `cmd_valid` until `cmd_ready` returns.
- `pending` is a 2-bit register, reset to STOP.
- Reset asserted mid-phase: immediately `speed` = 00, S_STOP, counter = 0, `pending` = STOP.

## Timing
- Reset values: `speed` = 00, `cmd_ready` = 1, `busy` = 0.
- A request accepted at edge N gives the new `speed` and state after edge N. `cmd_ready` falls in the same cycle when entering a transient state.
- `speed` = 11 persists exactly BRAKE_US cycles.
- `speed` = 00 in S_DEAD persists exactly DEAD_US cycles.
- Reversal latency from acceptance to the new drive code is BRAKE_US + DEAD_US + 1 edges.
- `cmd_ready` returns high in the same cycle the stable state is entered. A new request can be accepted on that edge.
- Parameter value 0 is illegal; the minimum is 1.

## Configuration
- `MOTOR_SEQ_WDOG_EN` defined:
  - A watchdog counter runs in S_FOR/S_BACK and clears on each accepted request, including no-ops.
  - When it reaches WDOG_US without a request, the block enters S_BRK with `pending` = STOP, exactly as for a STOP request.
  - Watchdog trips are not counted while in S_STOP.
- Undefined: no watchdog logic; drive persists indefinitely; WDOG_US is ignored.

## Structure
- Shared package `motor_pkg`: speed codes MOTOR_STOP/FOR/BACK/BRAKE, shared with the motor stage, plus the state enum.
- Single module; no sub-module needed. The phase counter and the watchdog counter are inline.

## Test plan
Bench parameters: BRAKE_US = 8, DEAD_US = 4, WDOG_US = 20.
- Reset release, no requests: `speed` = 00, `cmd_ready` = 1, `busy` = 0 for 50 cycles.
- FOR accepted at edge 10: `speed` = 01 from edge 10 on; `cmd_ready` stays 1.
- In S_FOR, STOP accepted: `speed` = 11 for exactly 8 cycles, then 00; `cmd_ready` = 0 for those 8 cycles.
- In S_FOR, BACK accepted: 11 ×8, 00 ×4, then 10; total 13 edges to `speed` = 10. `cmd_valid` held high during the phase is not accepted early.
- Reset asserted at cycle 3 of the brake phase: `speed` = 00 and `cmd_ready` = 1 immediately, without waiting for a clock edge.
- With `MOTOR_SEQ_WDOG_EN`: FOR, then no requests. 20 cycles later `speed` = 11 ×8, then 00. A repeated FOR every 15 cycles keeps `speed` = 01.

Source files
------------

// File: rtl/motor_pkg.sv
// motor_pkg: speed codes shared with the PWM motor stage and the sequencer state encoding.
package motor_pkg;
    typedef enum logic [1:0] {
        MOTOR_STOP  = 2'b00,
        MOTOR_FOR   = 2'b01,
        MOTOR_BACK  = 2'b10,
        MOTOR_BRAKE = 2'b11
    } speed_e;
    typedef enum logic [2:0] {S_STOP, S_FOR, S_BACK, S_BRK, S_DEAD} state_e;
endpackage

// File: rtl/motor_cmd_seq_if.sv
// motor_cmd_seq_if: valid/ready direction-request channel from the tracking/turn logic.
interface motor_cmd_seq_if;
    logic       cmd_valid;
    logic [1:0] cmd;
    logic       cmd_ready;
    modport master (output cmd_valid, output cmd, input cmd_ready);
    modport slave (input cmd_valid, input cmd, output cmd_ready);
endinterface

// File: rtl/motor_cmd_seq.sv
// motor_cmd_seq: inserts timed brake and reversal dead-time ahead of the motor stage.
// Optional drive watchdog enabled by defining MOTOR_SEQ_WDOG_EN.
module motor_cmd_seq
    import motor_pkg::*;
#(
    parameter int BRAKE_US = 200000,
    parameter int DEAD_US  = 50000,
    parameter int WDOG_US  = 500000,
    parameter int CNT_W    = 20
) (
    input  logic             clkus,
    input  logic             rst_n,
    motor_cmd_seq_if.slave   cmd_if,
    output logic [1:0]       speed,
    output logic             busy
);
    localparam logic [CNT_W-1:0] BRK_LAST  = CNT_W'(BRAKE_US - 1);
    localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD_US - 1);
    state_e           state_q, state_d;
    speed_e           pend_q, pend_d, speed_q, speed_d, req, own, opp;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rdy_q, rdy_d, acc, wdog_trip;
    assign req              = speed_e'(cmd_if.cmd);
    assign acc              = cmd_if.cmd_valid && rdy_q;
    assign own              = state_q == S_FOR ? MOTOR_FOR : MOTOR_BACK;
    assign opp              = state_q == S_FOR ? MOTOR_BACK : MOTOR_FOR;
    assign cmd_if.cmd_ready = rdy_q;
    assign speed            = speed_q;
    assign busy             = !rdy_q;
`ifdef MOTOR_SEQ_WDOG_EN
    localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(WDOG_US - 1);
    logic [CNT_W-1:0] wdog_q, wdog_d;
    assign wdog_trip = wdog_q == WDOG_LAST;
    always_comb begin
        wdog_d = ((state_d == S_FOR || state_d == S_BACK) && state_d == state_q && !acc) ? wdog_q + 1'b1 : '0;
    end
    always_ff @(posedge clkus or negedge rst_n) begin
        if (!rst_n) wdog_q <= '0;
        else        wdog_q <= wdog_d;
    end
`else
    assign wdog_trip = 1'b0;
`endif
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        case (state_q)
            S_STOP: begin
                if (acc && req == MOTOR_FOR) state_d = S_FOR;
                else if (acc && req == MOTOR_BACK) state_d = S_BACK;
                else if (acc && req == MOTOR_BRAKE) begin
                    state_d = S_BRK;
                    pend_d  = MOTOR_STOP;
                end
            end
            S_FOR, S_BACK: begin
                if (acc && req == opp) begin
                    state_d = S_BRK;
                    pend_d  = opp;
                end else if ((acc && req != own) || (!acc && wdog_trip)) begin
                    state_d = S_BRK;
                    pend_d  = MOTOR_STOP;
                end
            end
            S_BRK:   if (cnt_q == BRK_LAST) state_d = pend_q == MOTOR_STOP ? S_STOP : S_DEAD;
            S_DEAD:  if (cnt_q == DEAD_LAST) state_d = pend_q == MOTOR_FOR ? S_FOR : S_BACK;
            default: state_d = S_STOP;
        endcase
        cnt_d   = (state_d != state_q || !(state_q == S_BRK || state_q == S_DEAD)) ? '0 : cnt_q + 1'b1;
        rdy_d   = !(state_d == S_BRK || state_d == S_DEAD);
        speed_d = state_d == S_FOR  ? MOTOR_FOR  :
                  state_d == S_BACK ? MOTOR_BACK :
                  state_d == S_BRK  ? MOTOR_BRAKE : MOTOR_STOP;
    end
    always_ff @(posedge clkus or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_STOP;
            pend_q  <= MOTOR_STOP;
            speed_q <= MOTOR_STOP;
            cnt_q   <= '0;
            rdy_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            speed_q <= speed_d;
            cnt_q   <= cnt_d;
            rdy_q   <= rdy_d;
        end
    end
endmodule

// File: tb/tb_motor_cmd_seq.sv
// tb_motor_cmd_seq: directed checks of brake, dead-time, reversal, async reset and optional watchdog.
module tb_motor_cmd_seq;
    logic       clkus = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] speed;
    logic       busy;
    int         n_chk = 0;
    int         n_fail = 0;
    motor_cmd_seq_if cmd_if ();
    motor_cmd_seq #(.BRAKE_US(8), .DEAD_US(4), .WDOG_US(20), .CNT_W(20)) dut (
        .clkus(clkus), .rst_n(rst_n), .cmd_if(cmd_if), .speed(speed), .busy(busy)
    );
    always #5 clkus = ~clkus;

    task automatic send(input logic [1:0] c);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd = c;
        @(negedge clkus);
        cmd_if.cmd_valid = 1'b0;
    endtask

    task automatic test_reset;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd = 2'b00;
        rst_n = 1'b0;
        repeat (3) @(negedge clkus);
        rst_n = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clkus);
            n_chk++;
            if ({speed, cmd_if.cmd_ready, busy} !== 4'b0010) begin
                n_fail++;
                $display("FAIL reset_idle cyc %0d: got spd=%b rdy=%b busy=%b want 00/1/0", i, speed, cmd_if.cmd_ready, busy);
            end
        end
    endtask

    task automatic test_stop_noop;
        send(2'b00);
        repeat (3) begin
            n_chk++;
            if ({speed, cmd_if.cmd_ready} !== 3'b001) begin
                n_fail++;
                $display("FAIL stop_noop: got spd=%b rdy=%b want 00/1", speed, cmd_if.cmd_ready);
            end
            @(negedge clkus);
        end
    endtask

    task automatic test_for;
        send(2'b01);
        for (int i = 0; i < 5; i++) begin
            n_chk++;
            if ({speed, cmd_if.cmd_ready, busy} !== 4'b0110) begin
                n_fail++;
                $display("FAIL for_drive cyc %0d: got spd=%b rdy=%b busy=%b want 01/1/0", i, speed, cmd_if.cmd_ready, busy);
            end
            @(negedge clkus);
        end
    endtask

    task automatic test_brake(input logic [1:0] c, input string nm);
        send(c);
        for (int i = 0; i < 8; i++) begin
            n_chk++;
            if ({speed, cmd_if.cmd_ready, busy} !== 4'b1101) begin
                n_fail++;
                $display("FAIL %s brake cyc %0d: got spd=%b rdy=%b busy=%b want 11/0/1", nm, i, speed, cmd_if.cmd_ready, busy);
            end
            @(negedge clkus);
        end
        n_chk++;
        if ({speed, cmd_if.cmd_ready, busy} !== 4'b0010) begin
            n_fail++;
            $display("FAIL %s end: got spd=%b rdy=%b busy=%b want 00/1/0", nm, speed, cmd_if.cmd_ready, busy);
        end
    endtask

    task automatic test_reverse(input logic [1:0] to, input string nm);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd = to;
        for (int i = 0; i < 13; i++) begin
            @(negedge clkus);
            n_chk++;
            if (i < 8 && {speed, cmd_if.cmd_ready, busy} !== 4'b1101) begin
                n_fail++;
                $display("FAIL %s brake cyc %0d: got spd=%b rdy=%b want 11/0", nm, i, speed, cmd_if.cmd_ready);
            end else if (i >= 8 && i < 12 && {speed, cmd_if.cmd_ready, busy} !== 4'b0001) begin
                n_fail++;
                $display("FAIL %s dead cyc %0d: got spd=%b rdy=%b want 00/0", nm, i, speed, cmd_if.cmd_ready);
            end else if (i == 12 && {speed, cmd_if.cmd_ready, busy} !== {to, 2'b10}) begin
                n_fail++;
                $display("FAIL %s drive: got spd=%b rdy=%b want %b/1", nm, speed, cmd_if.cmd_ready, to);
            end
        end
        cmd_if.cmd_valid = 1'b0;
        @(negedge clkus);
    endtask

    task automatic test_reset_mid;
        send(2'b00);
        repeat (2) @(negedge clkus);
        #2 rst_n = 1'b0;
        #1;
        n_chk++;
        if ({speed, cmd_if.cmd_ready, busy} !== 4'b0010) begin
            n_fail++;
            $display("FAIL reset_mid async: got spd=%b rdy=%b busy=%b want 00/1/0", speed, cmd_if.cmd_ready, busy);
        end
        repeat (2) @(negedge clkus);
        rst_n = 1'b1;
        repeat (10) @(negedge clkus);
        n_chk++;
        if ({speed, cmd_if.cmd_ready} !== 3'b001) begin
            n_fail++;
            $display("FAIL reset_mid after: got spd=%b rdy=%b want 00/1", speed, cmd_if.cmd_ready);
        end
    endtask

    task automatic test_drive_hold;
        send(2'b01);
`ifdef MOTOR_SEQ_WDOG_EN
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 14; i++) @(negedge clkus);
            send(2'b01);
            n_chk++;
            if (speed !== 2'b01) begin
                n_fail++;
                $display("FAIL wdog_refresh round %0d: got spd=%b want 01", r, speed);
            end
        end
        for (int i = 0; i < 29; i++) begin
            n_chk++;
            if (i < 20 && speed !== 2'b01) begin
                n_fail++;
                $display("FAIL wdog_wait cyc %0d: got spd=%b want 01", i, speed);
            end else if (i >= 20 && i < 28 && speed !== 2'b11) begin
                n_fail++;
                $display("FAIL wdog_brake cyc %0d: got spd=%b want 11", i, speed);
            end else if (i == 28 && {speed, cmd_if.cmd_ready} !== 3'b001) begin
                n_fail++;
                $display("FAIL wdog_stop: got spd=%b rdy=%b want 00/1", speed, cmd_if.cmd_ready);
            end
            @(negedge clkus);
        end
`else
        for (int i = 0; i < 40; i++) begin
            n_chk++;
            if (speed !== 2'b01) begin
                n_fail++;
                $display("FAIL drive_persist cyc %0d: got spd=%b want 01", i, speed);
            end
            @(negedge clkus);
        end
        test_brake(2'b00, "persist_stop");
`endif
    endtask

    initial begin
        test_reset;
        test_stop_noop;
        test_for;
        test_brake(2'b00, "for_stop");
        test_brake(2'b11, "stop_brake");
        test_for;
        test_brake(2'b11, "for_brake");
        send(2'b10);
        test_reverse(2'b01, "back_to_for");
        test_reverse(2'b10, "for_to_back");
        test_reset_mid;
        test_drive_hold;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
